keccak_round_ctrl: RTL

//  Sequencer directly upstream of the masked state register (keccak_state).

---
 rtl/keccak_pkg.sv | 51 +++++
 rtl/keccak_rc_rom.sv | 12 +
 rtl/keccak_round_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak round sequencer: FSM encoding, size defaults
// and the 24-entry iota round-constant table.
`timescale 1ns/1ps
package keccak_pkg;

  localparam int unsigned SHARES_DEF  = 4;
  localparam int unsigned W_DEF       = 1600;
  localparam int unsigned ROUND_W     = 5;
  localparam int unsigned RC_W        = 64;
  localparam int unsigned MAX_ROUNDS  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Iota constants, indexed by round; unreachable indices return zero.
  function automatic logic [RC_W-1:0] keccak_rc(input logic [ROUND_W-1:0] idx);
    logic [RC_W-1:0] rc;
    case (idx)
      5'd0:    rc = 64'h0000_0000_0000_0001;
      5'd1:    rc = 64'h0000_0000_0000_8082;
      5'd2:    rc = 64'h8000_0000_0000_808A;
      5'd3:    rc = 64'h8000_0000_8000_8000;
      5'd4:    rc = 64'h0000_0000_0000_808B;
      5'd5:    rc = 64'h0000_0000_8000_0001;
      5'd6:    rc = 64'h8000_0000_8000_8081;
      5'd7:    rc = 64'h8000_0000_0000_8009;
      5'd8:    rc = 64'h0000_0000_0000_008A;
      5'd9:    rc = 64'h0000_0000_0000_0088;
      5'd10:   rc = 64'h0000_0000_8000_8009;
      5'd11:   rc = 64'h0000_0000_8000_000A;
      5'd12:   rc = 64'h0000_0000_8000_808B;
      5'd13:   rc = 64'h8000_0000_0000_008B;
      5'd14:   rc = 64'h8000_0000_0000_8089;
      5'd15:   rc = 64'h8000_0000_0000_8003;
      5'd16:   rc = 64'h8000_0000_0000_8002;
      5'd17:   rc = 64'h8000_0000_0000_0080;
      5'd18:   rc = 64'h0000_0000_0000_800A;
      5'd19:   rc = 64'h8000_0000_8000_000A;
      5'd20:   rc = 64'h8000_0000_8000_8081;
      5'd21:   rc = 64'h8000_0000_0000_8080;
      5'd22:   rc = 64'h0000_0000_8000_0001;
      5'd23:   rc = 64'h8000_0000_8000_8008;
      default: rc = '0;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/keccak_rc_rom.sv
// Combinational round-index to iota round-constant lookup.
`timescale 1ns/1ps
module keccak_rc_rom
  import keccak_pkg::*;
(
  input  logic [ROUND_W-1:0] round_i,
  output logic [RC_W-1:0]    rc_o
);

  assign rc_o = keccak_rc(round_i);

endmodule

// File: rtl/keccak_round_ctrl.sv
// Sequencer feeding the masked Keccak state register: load/round-output mux,
// write enable, round/cycle counters, iota constant and chi randomness request.
`timescale 1ns/1ps
module keccak_round_ctrl
  import keccak_pkg::*;
#(
  parameter int unsigned SHARES    = SHARES_DEF,
  parameter int unsigned W         = W_DEF,
  parameter int unsigned NROUNDS   = MAX_ROUNDS,
  parameter int unsigned ROUND_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [SHARES*W-1:0]   load_di,
  input  logic [SHARES*W-1:0]   round_do,
  input  logic                  abort_i,
  input  logic                  ack_i,
  output logic                  wen_o,
  output logic [SHARES*W-1:0]   state_di_o,
  output logic [RC_W-1:0]       rc_o,
  output logic [ROUND_W-1:0]    round_o,
  output logic                  rnd_req_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned CYC_W = $clog2(ROUND_CYC + 1);
  localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(ROUND_CYC - 1);
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NROUNDS - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ROUND_W-1:0] r_round;
  logic [ROUND_W-1:0] w_round_nxt;
  logic [CYC_W-1:0]   r_cyc;
  logic [CYC_W-1:0]   w_cyc_nxt;
  logic               w_wen;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_round <= '0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_cyc   <= w_cyc_nxt;
    end
  end

  // Next-state, counters and write enable; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_cyc_nxt   = r_cyc;
    w_wen       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_wen       = 1'b1;
          w_state_nxt = ST_ROUND;
          w_round_nxt = '0;
          w_cyc_nxt   = '0;
        end
      end
      ST_ROUND: begin
        if (r_cyc == CYC_LAST) begin
          w_wen     = 1'b1;
          w_cyc_nxt = '0;
          if (r_round == ROUND_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_round_nxt = r_round + ROUND_W'(1);
          end
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_DONE: begin
        if (ack_i) begin
          w_state_nxt = ST_IDLE;
          w_round_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_round_nxt = '0;
        w_cyc_nxt   = '0;
      end
    endcase
    if (abort_i) begin
      w_state_nxt = ST_IDLE;
      w_round_nxt = '0;
      w_cyc_nxt   = '0;
      w_wen       = 1'b0;
    end
  end

  keccak_rc_rom u_rc_rom (
    .round_i (r_round),
    .rc_o    (rc_o)
  );

  // Freshly loaded shares only pass through while waiting for a start.
  assign state_di_o = (r_state == ST_IDLE) ? load_di : round_do;
  assign wen_o      = w_wen;
  assign round_o    = r_round;
  assign rnd_req_o  = (r_state == ST_ROUND) && (r_cyc == '0);
  assign busy_o     = (r_state == ST_ROUND);
  assign done_o     = (r_state == ST_DONE);

endmodule
